// File: rtl/dual_mm_pkg.sv
//------------------------------------------------------------------------------
// Module  : dual_mm_pkg
// Brief   : Shared defaults and helpers for the dual-port-memory FIFO.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package dual_mm_pkg;

  localparam int DEFAULT_DEPTH = 8;
  localparam int DEFAULT_WIDTH = 8;

  // Address width needed to index a memory of the given depth.
  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage : dual_mm_pkg

`default_nettype wire

// File: rtl/dual_mm_ram.sv
//------------------------------------------------------------------------------
// Module  : dual_mm_ram
// Brief   : Simple dual-port storage array: synchronous write port and a
//           registered read port whose output holds when no read occurs.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dual_mm_ram
  import dual_mm_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int AW    = addr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Storage is intentionally not reset; only the queue pointers define validity.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read; a same-edge write to the read address returns the old word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule : dual_mm_ram

`default_nettype wire

// File: rtl/dual_mm_port_fifo.sv
//------------------------------------------------------------------------------
// Module  : dual_mm_port_fifo
// Brief   : Single-clock byte FIFO on a simple dual-port memory with a
//           registered read port and full/empty/count status.
//           Optional sticky overflow/underflow flags are built when the macro
//           DUAL_MM_ERR_FLAGS_EN is defined.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dual_mm_port_fifo
  import dual_mm_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en_i,
  input  logic                   rd_en_i,
  input  logic [WIDTH-1:0]       data_i,
  output logic [WIDTH-1:0]       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
`ifdef DUAL_MM_ERR_FLAGS_EN
  ,
  output logic                   ovf_o,
  output logic                   unf_o
`endif
);

  localparam int AW = addr_w(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          wr_acc;
  logic          rd_acc;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  // A read needs data present; a write needs room or a same-edge pop freeing a slot.
  // An empty FIFO never bypasses write data to the read port.
  assign rd_acc = rd_en_i && !empty_o;
  assign wr_acc = wr_en_i && (!full_o || rd_acc);

  // Next-state for pointers and occupancy; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset discards any queued data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  dual_mm_ram #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (data_i),
    .re_i    (rd_acc),
    .raddr_i (rd_ptr_q),
    .rdata_o (data_o)
  );

`ifdef DUAL_MM_ERR_FLAGS_EN
  logic ovf_q;
  logic unf_q;

  // Sticky error flags: any rejected request latches until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (wr_en_i && !wr_acc) begin
        ovf_q <= 1'b1;
      end
      if (rd_en_i && !rd_acc) begin
        unf_q <= 1'b1;
      end
    end
  end

  assign ovf_o = ovf_q;
  assign unf_o = unf_q;
`endif

endmodule : dual_mm_port_fifo

`default_nettype wire

// File: tb/tb_dual_mm_port_fifo.sv
//------------------------------------------------------------------------------
// Module  : tb_dual_mm_port_fifo
// Brief   : Self-checking bench for dual_mm_port_fifo: table-driven fill/drain
//           vectors, hand-written corner sequences, and randomized traffic
//           against a queue-based reference model. Honours DUAL_MM_ERR_FLAGS_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_dual_mm_port_fifo;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] din;
  logic [7:0] dout;
  logic       full;
  logic       empty;
  logic [3:0] count;
`ifdef DUAL_MM_ERR_FLAGS_EN
  logic       ovf;
  logic       unf;
`endif

  dual_mm_port_fifo #(.DEPTH(DEPTH), .WIDTH(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en_i (wr_en),
    .rd_en_i (rd_en),
    .data_i  (din),
    .data_o  (dout),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
`ifdef DUAL_MM_ERR_FLAGS_EN
    ,
    .ovf_o   (ovf),
    .unf_o   (unf)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: a plain queue of stored bytes plus the last value read.
  logic [7:0] mq[$];
  logic [7:0] m_dout;
  logic       m_ovf;
  logic       m_unf;

  typedef struct {
    logic       wr;
    logic       rd;
    logic [7:0] d;
    logic [7:0] e_data;
    logic [3:0] e_cnt;
    logic       e_full;
    logic       e_empty;
  } vec_t;

  vec_t tbl[18];

  function automatic vec_t mkv(input logic w, input logic r, input logic [7:0] d,
                               input logic [7:0] ed, input logic [3:0] ec,
                               input logic ef, input logic ee);
    vec_t v;
    v.wr = w; v.rd = r; v.d = d; v.e_data = ed; v.e_cnt = ec;
    v.e_full = ef; v.e_empty = ee;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_dout = 8'h00;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".data"},  {24'd0, dout},  {24'd0, m_dout});
    chk({tag, ".count"}, {28'd0, count}, mq.size());
    chk({tag, ".full"},  {31'd0, full},  {31'd0, (mq.size() == DEPTH)});
    chk({tag, ".empty"}, {31'd0, empty}, {31'd0, (mq.size() == 0)});
`ifdef DUAL_MM_ERR_FLAGS_EN
    chk({tag, ".ovf"}, {31'd0, ovf}, {31'd0, m_ovf});
    chk({tag, ".unf"}, {31'd0, unf}, {31'd0, m_unf});
`endif
  endtask

  // One clock: drive, let the edge happen, advance the model, check after the edge.
  task automatic step(input logic w, input logic r, input logic [7:0] d, input string tag);
    bit racc;
    bit wacc;
    wr_en = w;
    rd_en = r;
    din   = d;
    @(posedge clk);
    racc = r && (mq.size() > 0);
    wacc = w && ((mq.size() < DEPTH) || racc);
    if (w && !wacc) m_ovf = 1'b1;
    if (r && !racc) m_unf = 1'b1;
    if (racc) m_dout = mq.pop_front();
    if (wacc) mq.push_back(d);
    #1;
    chk_model(tag);
  endtask

  // Asynchronous reset pulse between edges; outputs must clear without a clock.
  task automatic async_reset(input string tag);
    wr_en = 1'b0;
    rd_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk({tag, ".rst_count"}, {28'd0, count}, 32'd0);
    chk({tag, ".rst_empty"}, {31'd0, empty}, 32'd1);
    chk({tag, ".rst_full"},  {31'd0, full},  32'd0);
    chk({tag, ".rst_data"},  {24'd0, dout},  32'd0);
`ifdef DUAL_MM_ERR_FLAGS_EN
    chk({tag, ".rst_ovf"}, {31'd0, ovf}, 32'd0);
    chk({tag, ".rst_unf"}, {31'd0, unf}, 32'd0);
`endif
    model_clear();
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst   = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    din   = 8'h00;
    model_clear();

    // Fill 0..7, one rejected write, drain 0..7, one rejected read.
    for (int i = 0; i < 8; i++)
      tbl[i] = mkv(1'b1, 1'b0, 8'(i), 8'h00, 4'(i + 1), (i == 7), 1'b0);
    tbl[8] = mkv(1'b1, 1'b0, 8'd7, 8'h00, 4'd8, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++)
      tbl[9 + i] = mkv(1'b0, 1'b1, 8'h00, 8'(i), 4'(7 - i), 1'b0, (i == 7));
    tbl[17] = mkv(1'b0, 1'b1, 8'h00, 8'd7, 4'd0, 1'b0, 1'b1);

    // Reset state while reset is held.
    #12;
    chk("init.count", {28'd0, count}, 32'd0);
    chk("init.empty", {31'd0, empty}, 32'd1);
    chk("init.full",  {31'd0, full},  32'd0);
    chk("init.data",  {24'd0, dout},  32'd0);
    #11 rst = 1'b0;
    @(posedge clk);
    #1;

    // Mid-stream reset with three entries queued and a non-zero data_o.
    step(1'b1, 1'b0, 8'hA1, "pre");
    step(1'b1, 1'b0, 8'hB2, "pre");
    step(1'b0, 1'b1, 8'h00, "pre");
    step(1'b1, 1'b0, 8'hC3, "pre");
    step(1'b1, 1'b0, 8'hD4, "pre");
    chk("pre.count3", {28'd0, count}, 32'd3);
    chk("pre.dataA1", {24'd0, dout},  32'hA1);
    async_reset("midrst");

    // Table-driven fill/drain.
    for (int i = 0; i < 18; i++) begin
      step(tbl[i].wr, tbl[i].rd, tbl[i].d, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d.vdata", i),  {24'd0, dout},  {24'd0, tbl[i].e_data});
      chk($sformatf("tbl%0d.vcount", i), {28'd0, count}, {28'd0, tbl[i].e_cnt});
      chk($sformatf("tbl%0d.vfull", i),  {31'd0, full},  {31'd0, tbl[i].e_full});
      chk($sformatf("tbl%0d.vempty", i), {31'd0, empty}, {31'd0, tbl[i].e_empty});
    end
`ifdef DUAL_MM_ERR_FLAGS_EN
    chk("tbl.ovf_sticky", {31'd0, ovf}, 32'd1);
    chk("tbl.unf_sticky", {31'd0, unf}, 32'd1);
`endif

    // Simultaneous write and read while empty: write only, no bypass.
    step(1'b1, 1'b1, 8'h33, "simul_empty");
    chk("simul_empty.count", {28'd0, count}, 32'd1);
    chk("simul_empty.data",  {24'd0, dout},  32'd7);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 8'(8'h40 + i), "fill");
    chk("fill.full", {31'd0, full}, 32'd1);
    // Simultaneous write and read while full: both accepted, count holds.
    step(1'b1, 1'b1, 8'h44, "simul_full");
    chk("simul_full.count", {28'd0, count}, 32'd8);
    chk("simul_full.data",  {24'd0, dout},  32'h33);
    chk("simul_full.full",  {31'd0, full},  32'd1);

    // Randomized traffic in write-heavy, read-heavy and balanced phases.
    for (int ph = 0; ph < 3; ph++) begin
      int wpct;
      int rpct;
      wpct = (ph == 0) ? 80 : (ph == 1) ? 25 : 50;
      rpct = (ph == 0) ? 25 : (ph == 1) ? 80 : 50;
      for (int i = 0; i < 100; i++) begin
        step(($urandom_range(0, 99) < wpct), ($urandom_range(0, 99) < rpct),
             8'($urandom), $sformatf("rnd%0d_%0d", ph, i));
      end
    end

    // Idle hold after reading 0x5A.
    async_reset("rst2");
    step(1'b1, 1'b0, 8'h5A, "hold_wr");
    step(1'b0, 1'b1, 8'h00, "hold_rd");
    chk("hold.read5A", {24'd0, dout}, 32'h5A);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 8'hFF, "idle");
      chk($sformatf("idle%0d.data", i), {24'd0, dout}, 32'h5A);
    end
    step(1'b0, 1'b1, 8'h00, "underflow");
    chk("underflow.data", {24'd0, dout}, 32'h5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_dual_mm_port_fifo

`default_nettype wire
